eim_mem_arbiter: RTL

- Shares one single-port 256x8 register memory between two requesters: the EIM bus front end (CPU side) and a local FPGA-side client.
- The EIM front end hands over synchronized, edge-detected single-cycle strobes. This block queues them, sequences memory accesses and drives eim_wait_n so CPU reads stall until data is ready.
- Sits between the EIM pin/CDC logic and the memory. A bounded starvation guard guarantees the local client forward progress.

---
 rtl/eim_mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/eim_mem_arbiter.sv
// eim_mem_arbiter
// Shares one single-port register memory between the EIM bus front end
// (CPU side) and a local FPGA-side client. EIM strobes are queued in one
// read slot and one write slot; reads stall the CPU through eim_wait_n.
// A saturating starvation counter forces a local slot after STARVE_LIMIT
// consecutive EIM grants while the local client is waiting.
module eim_mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  eim_rd_req,
    input  logic                  eim_wr_req,
    input  logic [ADDR_WIDTH-1:0] eim_addr,
    input  logic [DATA_WIDTH-1:0] eim_wdata,
    output logic [DATA_WIDTH-1:0] eim_rdata,
    output logic                  eim_rd_valid,
    output logic                  eim_wait_n,
    output logic                  eim_ovf,
    input  logic                  ovf_clr,
    input  logic                  loc_req,
    input  logic                  loc_we,
    input  logic [ADDR_WIDTH-1:0] loc_addr,
    input  logic [DATA_WIDTH-1:0] loc_wdata,
    output logic                  loc_gnt,
    output logic [DATA_WIDTH-1:0] loc_rdata,
    output logic                  loc_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] RDATA = 1'b1;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [0:0]            state;
    logic                  owner_loc;   // RDATA owner: 1 = local client, 0 = EIM

    logic                  rd_v;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_v;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [3:0]            starve_cnt;

    logic                  grant_wr;
    logic                  grant_rd;
    logic                  grant_loc;
    logic                  wr_free;
    logic                  rd_done;
    logic                  ovf_set;

    // The write slot may be refilled in the same cycle it drains, which is
    // what sustains one EIM write per cycle.
    assign wr_free = !wr_v || grant_wr;
    assign rd_done = (state == RDATA) && !owner_loc;
    assign ovf_set = (eim_wr_req && !wr_free) || (eim_rd_req && rd_v);
    assign loc_gnt = grant_loc;

    // Pick one winner in IDLE: forced local, then write, read, local.
    always_comb begin
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        grant_loc = 1'b0;
        if (state == IDLE) begin
            if (loc_req && (starve_cnt == LIMIT)) grant_loc = 1'b1;
            else if (wr_v)                        grant_wr  = 1'b1;
            else if (rd_v)                        grant_rd  = 1'b1;
            else if (loc_req)                     grant_loc = 1'b1;
        end
    end

    // Drive the memory port from the current winner; idle port reads as zero.
    always_comb begin
        mem_en    = grant_wr | grant_rd | grant_loc;
        mem_we    = grant_wr | (grant_loc & loc_we);
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_wr) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (grant_rd) begin
            mem_addr  = rd_addr;
        end else if (grant_loc) begin
            mem_addr  = loc_addr;
            if (loc_we) mem_wdata = loc_wdata;
        end
    end

    // Sequencer: reads park in RDATA for one cycle to capture memory data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_loc    <= 1'b0;
            eim_rdata    <= '0;
            loc_rdata    <= '0;
            eim_rd_valid <= 1'b0;
            loc_rvalid   <= 1'b0;
        end else begin
            eim_rd_valid <= 1'b0;
            loc_rvalid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_rd || (grant_loc && !loc_we)) begin
                        state     <= RDATA;
                        owner_loc <= grant_loc;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (owner_loc) begin
                        loc_rdata  <= mem_rdata;
                        loc_rvalid <= 1'b1;
                    end else begin
                        eim_rdata    <= mem_rdata;
                        eim_rd_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Pending EIM slots and the CPU wait line that tracks the read slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_v       <= 1'b0;
            rd_addr    <= '0;
            wr_v       <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            eim_wait_n <= 1'b1;
        end else begin
            if (grant_wr) wr_v <= 1'b0;
            if (eim_wr_req && wr_free) begin
                wr_v    <= 1'b1;
                wr_addr <= eim_addr;
                wr_data <= eim_wdata;
            end
            if (rd_done) begin
                rd_v       <= 1'b0;
                eim_wait_n <= 1'b1;
            end else if (eim_rd_req && !rd_v) begin
                rd_v       <= 1'b1;
                rd_addr    <= eim_addr;
                eim_wait_n <= 1'b0;
            end
        end
    end

    // Count EIM grants taken while the local client waits; saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!loc_req || grant_loc) begin
            starve_cnt <= '0;
        end else if ((grant_wr || grant_rd) && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Sticky overflow flag; a new overflow wins over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n)       eim_ovf <= 1'b0;
        else if (ovf_set) eim_ovf <= 1'b1;
        else if (ovf_clr) eim_ovf <= 1'b0;
    end

endmodule
